rename_register_file: RTL and testbench
=======================================

Name: rename_register_file

Overview:
Parametrised architectural register file with per-register rename tags. It tracks which ROB entry will produce each register and serves NREAD combinational operand-read channels to the decoder, with commit bypass. It retires committed values and broadcasts each commit to the reservation stations one cycle later. It adds a global flush (mispredict recovery) that clears all pending renames in one cycle.

Parameters:
XLEN, 32, data width of each register and of commit values
NREG, 32, number of architectural registers (power of two, at least 2); register 0 is hardwired zero
ROB_W, 5, ROB id width
NREAD, 2, number of independent operand-read channels
REG_W, $clog2(NREG), register index width (derived, not overridable)

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  when low, all state and registered outputs hold
_flush  in  1  mispredict flush; clears every busy flag at the clock edge
_rob_launch_ready  in  1  rename request valid
_rob_launch_rob_id  in  ROB_W  ROB id of the launching instruction
_rob_launch_register_id  in  REG_W  destination register of the launch
_rob_commit_ready  in  1  commit valid
_rob_commit_rob_id  in  ROB_W  ROB id being committed
_rob_commit_register_id  in  REG_W  destination register of the commit
_rob_commit_value  in  XLEN  committed value
_read_register_id  in  NREAD*REG_W  per-channel source register, channel k in bits [k*REG_W +: REG_W]
_read_has_dependency  out  NREAD  per channel: 1 = operand pending
_read_dependency  out  NREAD*ROB_W  per channel: producing ROB id, valid when the dependency bit is set, else 0
_read_value  out  NREAD*XLEN  per channel: operand value, valid when the dependency bit is clear, else 0
_rf_msg_ready  out  1  commit broadcast valid
_rf_msg_rob_id  out  ROB_W  broadcast ROB id
_rf_msg_value  out  XLEN  broadcast value

Behaviour:
- State per register r: value[r] (XLEN), busy[r] (1), tag[r] (ROB_W). Register 0 is never busy and always reads 0. Writes and launches targeting register 0 are ignored.
- Reset (async, rst_in=1): all value, busy and tag entries are 0. _rf_msg_ready, _rf_msg_rob_id and _rf_msg_value are 0. Read outputs follow the zeroed state (no dependency, value 0).
- All updates below occur at posedge clk_in only when rdy_in=1. With rdy_in=0 nothing changes, and _rf_msg_* hold their previous values.
- Commit, when _rob_commit_ready=1 and the register is nonzero:
  - value[rd] <= commit value.
  - If busy[rd] and tag[rd] equals the commit ROB id, busy[rd] <= 0.
  - A stale commit (tag mismatch) writes the value but leaves busy and tag untouched.
- Launch, when _rob_launch_ready=1, _flush=0 and the register is nonzero: busy[rd] <= 1 and tag[rd] <= launch ROB id.
  - A launch and commit to the same register in the same cycle: launch wins on busy and tag; the value is still written.
- Flush (_flush=1): every busy bit is cleared. The same-cycle launch is discarded. A same-cycle commit still writes its value.
- Read channel k (combinational, decided independently per channel):
  - Register 0: no dependency, value 0.
  - Else if not busy: no dependency, value[r].
  - Else if _rob_commit_ready=1 and rdy_in=1 and the commit ROB id equals tag[r] (same-cycle bypass): no dependency, value = commit value.
  - Else: dependency set, dependency id = tag[r], value 0.
  - Reads see pre-launch state. A same-cycle launch is invisible to reads, so an instruction reading its own destination gets the previous producer.
- Broadcast: latency is 1 cycle. The cycle after an accepted commit, _rf_msg_ready=1 with that commit's ROB id and value, for exactly one cycle. This applies to commits to register 0 as well.
  - _rf_msg_ready <= commit_ready and not _flush. When it is 0, the id and value registers hold.
  - Back-to-back commits produce back-to-back broadcasts.
- No internal state machine beyond the arrays; there is no backpressure.

Decomposition:
- Shared package: XLEN, ROB_W and the default NREG as localparams; a function for the flattened-vector slice index.
- Sub-module rrf_read_port: one read-channel lookup with commit bypass, instantiated NREAD times via generate. The top level owns the arrays and the broadcast register.

Test Plan:
- Reset mid-run: after writing r5=0x1234 and launching r5 with tag 3, pulse rst_in asynchronously. Require: r5 reads value 0 with no dependency; _rf_msg_ready=0 immediately, before any clock edge.
- Launch then commit: launch r7 with tag 9; the next cycle channel 0 reads r7 with dependency=1 and id 9. Commit tag 9, r7, 0xDEADBEEF. Require: in the commit cycle channel 0 bypasses to 0xDEADBEEF with no dependency; the next cycle the broadcast shows id 9 and value 0xDEADBEEF; after that, r7 is not busy.
- Stale commit: launch r4 with tag 2, then launch r4 with tag 6, then commit tag 2 with r4=0x11. Require: value[r4]=0x11, r4 still pending on tag 6, and the broadcast still shows id 2.
- Simultaneous launch and commit on r3 (commit tag 1, launch tag 4). Require: r3 pending on tag 4, and value[r3] equals the committed value.
- Flush: with r1 pending on tag 2 and r2 pending on tag 5, assert _flush together with a launch of r6 and a commit of r8=0x55. Require: r1, r2 and r6 not busy; r8=0x55; no broadcast the following cycle.
- rdy_in=0 for 3 cycles while commits and launches are presented. Require: no state change, and _rf_msg_* hold their values. Register 0 reads 0 on all NREAD channels even after a commit to register 0 with value 0xFF.

Source files
------------

// File: rtl/rename_register_file_pkg.sv
// Shared constants and helpers for the rename register file.
// Holds the default widths used by the top level and its read ports.
// No logic; import with rename_register_file_pkg::*.
package rename_register_file_pkg;

    localparam int RRF_XLEN  = 32;
    localparam int RRF_ROB_W = 5;
    localparam int RRF_NREG  = 32;

    // Low bit of element idx inside a flattened vector of width-bit elements.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rrf_read_port.sv
// One combinational operand-read channel of the rename register file.
// Ports: reg_id selects the source; busy_vec/tag_vec/value_vec are the
// flattened register arrays; commit_* feed the same-cycle bypass.
// Outputs: has_dependency, dependency (ROB id), value.
module rrf_read_port
    import rename_register_file_pkg::*;
#(
    parameter int XLEN  = RRF_XLEN,
    parameter int NREG  = RRF_NREG,
    parameter int ROB_W = RRF_ROB_W,
    localparam int REG_W = $clog2(NREG)
)(
    input  logic [REG_W-1:0]      reg_id,
    input  logic [NREG-1:0]       busy_vec,
    input  logic [NREG*ROB_W-1:0] tag_vec,
    input  logic [NREG*XLEN-1:0]  value_vec,
    input  logic                  commit_ready,
    input  logic                  rdy,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [XLEN-1:0]       commit_value,
    output logic                  has_dependency,
    output logic [ROB_W-1:0]      dependency,
    output logic [XLEN-1:0]       value
);

    logic [ROB_W-1:0] cur_tag;
    logic [XLEN-1:0]  cur_value;

    assign cur_tag   = tag_vec[reg_id * ROB_W +: ROB_W];
    assign cur_value = value_vec[reg_id * XLEN +: XLEN];

    always_comb begin
        has_dependency = 1'b0;
        dependency     = '0;
        value          = '0;
        if (reg_id != '0) begin
            if (!busy_vec[reg_id]) begin
                value = cur_value;
            end else if (commit_ready && rdy && (commit_rob_id == cur_tag)) begin
                // Producer is committing right now: forward its value.
                value = commit_value;
            end else begin
                has_dependency = 1'b1;
                dependency     = cur_tag;
            end
        end
    end

endmodule

// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags, NREAD
// combinational read channels with commit bypass, a one-cycle-late commit
// broadcast and a single-cycle flush of all pending renames.
// Ports: clk_in/rst_in/rdy_in, _flush, _rob_launch_*, _rob_commit_*,
// _read_* (flattened per channel), _rf_msg_* (broadcast).
module rename_register_file
    import rename_register_file_pkg::*;
#(
    parameter int XLEN  = RRF_XLEN,
    parameter int NREG  = RRF_NREG,
    parameter int ROB_W = RRF_ROB_W,
    parameter int NREAD = 2,
    localparam int REG_W = $clog2(NREG)
)(
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   _flush,
    input  logic                   _rob_launch_ready,
    input  logic [ROB_W-1:0]       _rob_launch_rob_id,
    input  logic [REG_W-1:0]       _rob_launch_register_id,
    input  logic                   _rob_commit_ready,
    input  logic [ROB_W-1:0]       _rob_commit_rob_id,
    input  logic [REG_W-1:0]       _rob_commit_register_id,
    input  logic [XLEN-1:0]        _rob_commit_value,
    input  logic [NREAD*REG_W-1:0] _read_register_id,
    output logic [NREAD-1:0]       _read_has_dependency,
    output logic [NREAD*ROB_W-1:0] _read_dependency,
    output logic [NREAD*XLEN-1:0]  _read_value,
    output logic                   _rf_msg_ready,
    output logic [ROB_W-1:0]       _rf_msg_rob_id,
    output logic [XLEN-1:0]        _rf_msg_value
);

    // Flattened register state; entry 0 is only ever reset, so it stays 0.
    logic [NREG-1:0]       busy_q;
    logic [NREG*ROB_W-1:0] tag_q;
    logic [NREG*XLEN-1:0]  value_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            tag_q   <= '0;
            value_q <= '0;
        end else if (rdy_in) begin
            for (int r = 1; r < NREG; r++) begin
                if (_rob_commit_ready && (_rob_commit_register_id == REG_W'(r))) begin
                    value_q[r*XLEN +: XLEN] <= _rob_commit_value;
                    // Only the current producer may release the rename.
                    if (busy_q[r] && (tag_q[r*ROB_W +: ROB_W] == _rob_commit_rob_id)) begin
                        busy_q[r] <= 1'b0;
                    end
                end
                // Later assignments override the commit release above.
                if (_flush) begin
                    busy_q[r] <= 1'b0;
                end else if (_rob_launch_ready && (_rob_launch_register_id == REG_W'(r))) begin
                    busy_q[r]               <= 1'b1;
                    tag_q[r*ROB_W +: ROB_W] <= _rob_launch_rob_id;
                end
            end
        end
    end

    // Broadcast register: id/value hold whenever no broadcast is issued.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            _rf_msg_ready  <= 1'b0;
            _rf_msg_rob_id <= '0;
            _rf_msg_value  <= '0;
        end else if (rdy_in) begin
            _rf_msg_ready <= _rob_commit_ready && !_flush;
            if (_rob_commit_ready && !_flush) begin
                _rf_msg_rob_id <= _rob_commit_rob_id;
                _rf_msg_value  <= _rob_commit_value;
            end
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_read
        rrf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .ROB_W (ROB_W)
        ) u_read_port (
            .reg_id         (_read_register_id[slice_lo(k, REG_W) +: REG_W]),
            .busy_vec       (busy_q),
            .tag_vec        (tag_q),
            .value_vec      (value_q),
            .commit_ready   (_rob_commit_ready),
            .rdy            (rdy_in),
            .commit_rob_id  (_rob_commit_rob_id),
            .commit_value   (_rob_commit_value),
            .has_dependency (_read_has_dependency[k]),
            .dependency     (_read_dependency[slice_lo(k, ROB_W) +: ROB_W]),
            .value          (_read_value[slice_lo(k, XLEN) +: XLEN])
        );
    end

endmodule

// File: tb/tb_rename_register_file.sv
module tb_rename_register_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int ROB_W = 5;
    localparam int NREAD = 2;
    localparam int REG_W = 5;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   _flush;
    logic                   _rob_launch_ready;
    logic [ROB_W-1:0]       _rob_launch_rob_id;
    logic [REG_W-1:0]       _rob_launch_register_id;
    logic                   _rob_commit_ready;
    logic [ROB_W-1:0]       _rob_commit_rob_id;
    logic [REG_W-1:0]       _rob_commit_register_id;
    logic [XLEN-1:0]        _rob_commit_value;
    logic [NREAD*REG_W-1:0] _read_register_id;
    logic [NREAD-1:0]       _read_has_dependency;
    logic [NREAD*ROB_W-1:0] _read_dependency;
    logic [NREAD*XLEN-1:0]  _read_value;
    logic                   _rf_msg_ready;
    logic [ROB_W-1:0]       _rf_msg_rob_id;
    logic [XLEN-1:0]        _rf_msg_value;

    rename_register_file #(
        .XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NREAD(NREAD)
    ) dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .rdy_in                  (rdy_in),
        ._flush                  (_flush),
        ._rob_launch_ready       (_rob_launch_ready),
        ._rob_launch_rob_id      (_rob_launch_rob_id),
        ._rob_launch_register_id (_rob_launch_register_id),
        ._rob_commit_ready       (_rob_commit_ready),
        ._rob_commit_rob_id      (_rob_commit_rob_id),
        ._rob_commit_register_id (_rob_commit_register_id),
        ._rob_commit_value       (_rob_commit_value),
        ._read_register_id       (_read_register_id),
        ._read_has_dependency    (_read_has_dependency),
        ._read_dependency        (_read_dependency),
        ._read_value             (_read_value),
        ._rf_msg_ready           (_rf_msg_ready),
        ._rf_msg_rob_id          (_rf_msg_rob_id),
        ._rf_msg_value           (_rf_msg_value)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy, flush, lr;
        logic [4:0]  lrob, lreg;
        logic        cr;
        logic [4:0]  crob, creg;
        logic [31:0] cval;
        logic [4:0]  rd0, rd1;
        logic        e_dep;
        logic [4:0]  e_id;
        logic [31:0] e_val;
        logic        e_mrdy;
        logic [4:0]  e_mid;
        logic [31:0] e_mval;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_val  [NREG];
    logic        m_busy [NREG];
    logic [4:0]  m_tag  [NREG];
    logic        m_mrdy;
    logic [4:0]  m_mid;
    logic [31:0] m_mval;

    vec_t tbl [28];

    function automatic vec_t mk(input logic rdy, flush, lr, input logic [4:0] lrob, lreg,
                                input logic cr, input logic [4:0] crob, creg,
                                input logic [31:0] cval, input logic [4:0] rd0, rd1,
                                input logic e_dep, input logic [4:0] e_id, input logic [31:0] e_val,
                                input logic e_mrdy, input logic [4:0] e_mid, input logic [31:0] e_mval);
        vec_t v;
        v.rdy = rdy; v.flush = flush; v.lr = lr; v.lrob = lrob; v.lreg = lreg;
        v.cr = cr; v.crob = crob; v.creg = creg; v.cval = cval;
        v.rd0 = rd0; v.rd1 = rd1;
        v.e_dep = e_dep; v.e_id = e_id; v.e_val = e_val;
        v.e_mrdy = e_mrdy; v.e_mid = e_mid; v.e_mval = e_mval;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
        m_mrdy = 1'b0; m_mid = '0; m_mval = '0;
    endtask

    task automatic drive(input vec_t v);
        rdy_in                  = v.rdy;
        _flush                  = v.flush;
        _rob_launch_ready       = v.lr;
        _rob_launch_rob_id      = v.lrob;
        _rob_launch_register_id = v.lreg;
        _rob_commit_ready       = v.cr;
        _rob_commit_rob_id      = v.crob;
        _rob_commit_register_id = v.creg;
        _rob_commit_value       = v.cval;
        _read_register_id       = {v.rd1, v.rd0};
    endtask

    // Expected operand for one source register given current state and inputs.
    task automatic model_read(input logic [4:0] r, output logic dep,
                              output logic [4:0] id, output logic [31:0] val);
        dep = 1'b0; id = '0; val = '0;
        if (r == 0)                   val = '0;
        else if (!m_busy[r])          val = m_val[r];
        else if (_rob_commit_ready && rdy_in && _rob_commit_rob_id == m_tag[r])
                                      val = _rob_commit_value;
        else begin dep = 1'b1; id = m_tag[r]; end
    endtask

    task automatic check_model();
        logic dep; logic [4:0] id; logic [31:0] val;
        for (int k = 0; k < NREAD; k++) begin
            model_read(_read_register_id[k*REG_W +: REG_W], dep, id, val);
            check($sformatf("model_dep_ch%0d", k), _read_has_dependency[k], dep);
            check($sformatf("model_id_ch%0d", k), _read_dependency[k*ROB_W +: ROB_W], id);
            check($sformatf("model_val_ch%0d", k), _read_value[k*XLEN +: XLEN], val);
        end
        check("model_msg_ready", _rf_msg_ready, m_mrdy);
        check("model_msg_id", _rf_msg_rob_id, m_mid);
        check("model_msg_value", _rf_msg_value, m_mval);
    endtask

    // Applies the clock-edge rules to the model using the inputs still driven.
    task automatic model_edge();
        logic [4:0] cr_reg;
        if (!rdy_in) return;
        cr_reg = _rob_commit_register_id;
        if (_rob_commit_ready && !_flush) begin
            m_mrdy = 1'b1; m_mid = _rob_commit_rob_id; m_mval = _rob_commit_value;
        end else begin
            m_mrdy = 1'b0;
        end
        if (_rob_commit_ready && cr_reg != 0) begin
            m_val[cr_reg] = _rob_commit_value;
            if (m_busy[cr_reg] && m_tag[cr_reg] == _rob_commit_rob_id) m_busy[cr_reg] = 1'b0;
        end
        if (_flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end else if (_rob_launch_ready && _rob_launch_register_id != 0) begin
            m_busy[_rob_launch_register_id] = 1'b1;
            m_tag[_rob_launch_register_id]  = _rob_launch_rob_id;
        end
    endtask

    task automatic run_cycle(input vec_t v);
        @(negedge clk_in);
        drive(v);
        #1;
        check_model();
        @(posedge clk_in);
        model_edge();
    endtask

    initial begin
        vec_t v;
        vec_t idle;
        //          rdy flush lr lrob lreg cr crob creg cval         rd0 rd1 dep id val           mrdy mid mval
        tbl[0]  = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        0,  0,  0, 0, 32'h0,        0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 9,  7,  0, 0,  0,  32'h0,        7,  1,  0, 0, 32'h0,        0, 0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        7,  7,  1, 9, 32'h0,        0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 0, 0,  0,  1, 9,  7,  32'hDEADBEEF, 7,  2,  0, 0, 32'hDEADBEEF, 0, 0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        7,  0,  0, 0, 32'hDEADBEEF, 1, 9, 32'hDEADBEEF);
        tbl[5]  = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        7,  7,  0, 0, 32'hDEADBEEF, 0, 9, 32'hDEADBEEF);
        tbl[6]  = mk(1, 0, 1, 2,  4,  0, 0,  0,  32'h0,        4,  4,  0, 0, 32'h0,        0, 9, 32'hDEADBEEF);
        tbl[7]  = mk(1, 0, 1, 6,  4,  0, 0,  0,  32'h0,        4,  7,  1, 2, 32'h0,        0, 9, 32'hDEADBEEF);
        tbl[8]  = mk(1, 0, 0, 0,  0,  1, 2,  4,  32'h11,       4,  4,  1, 6, 32'h0,        0, 9, 32'hDEADBEEF);
        tbl[9]  = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        4,  0,  1, 6, 32'h0,        1, 2, 32'h11);
        tbl[10] = mk(1, 0, 1, 1,  3,  0, 0,  0,  32'h0,        3,  4,  0, 0, 32'h0,        0, 2, 32'h11);
        tbl[11] = mk(1, 0, 1, 4,  3,  1, 1,  3,  32'hA5A5,     3,  3,  0, 0, 32'hA5A5,     0, 2, 32'h11);
        tbl[12] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        3,  4,  1, 4, 32'h0,        1, 1, 32'hA5A5);
        tbl[13] = mk(1, 0, 1, 2,  1,  0, 0,  0,  32'h0,        1,  3,  0, 0, 32'h0,        0, 1, 32'hA5A5);
        tbl[14] = mk(1, 0, 1, 5,  2,  0, 0,  0,  32'h0,        1,  2,  1, 2, 32'h0,        0, 1, 32'hA5A5);
        tbl[15] = mk(1, 1, 1, 7,  6,  1, 31, 8,  32'h55,       2,  1,  1, 5, 32'h0,        0, 1, 32'hA5A5);
        tbl[16] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        1,  2,  0, 0, 32'h0,        0, 1, 32'hA5A5);
        tbl[17] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        6,  3,  0, 0, 32'h0,        0, 1, 32'hA5A5);
        tbl[18] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        8,  4,  0, 0, 32'h55,       0, 1, 32'hA5A5);
        tbl[19] = mk(1, 0, 1, 3,  12, 1, 8,  11, 32'h99,       4,  8,  0, 0, 32'h11,       0, 1, 32'hA5A5);
        tbl[20] = mk(0, 0, 1, 3,  10, 1, 3,  9,  32'h77,       9,  12, 0, 0, 32'h0,        1, 8, 32'h99);
        tbl[21] = mk(0, 0, 1, 3,  10, 1, 3,  9,  32'h77,       12, 10, 1, 3, 32'h0,        1, 8, 32'h99);
        tbl[22] = mk(0, 0, 1, 3,  10, 1, 3,  9,  32'h77,       11, 9,  0, 0, 32'h99,       1, 8, 32'h99);
        tbl[23] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        9,  11, 0, 0, 32'h0,        1, 8, 32'h99);
        tbl[24] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        10, 12, 0, 0, 32'h0,        0, 8, 32'h99);
        tbl[25] = mk(1, 0, 0, 0,  0,  1, 4,  0,  32'hFF,       0,  0,  0, 0, 32'h0,        0, 8, 32'h99);
        tbl[26] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        0,  0,  0, 0, 32'h0,        1, 4, 32'hFF);
        tbl[27] = mk(1, 0, 0, 0,  0,  0, 0,  0,  32'h0,        12, 0,  1, 3, 32'h0,        0, 4, 32'hFF);

        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        rst_in = 1'b1;
        drive(idle);
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        // Directed table: hand-derived channel-0 and broadcast expectations.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk_in);
            drive(tbl[i]);
            #1;
            check($sformatf("tbl%0d_dep", i), _read_has_dependency[0], tbl[i].e_dep);
            check($sformatf("tbl%0d_id", i), _read_dependency[ROB_W-1:0], tbl[i].e_id);
            check($sformatf("tbl%0d_val", i), _read_value[XLEN-1:0], tbl[i].e_val);
            check($sformatf("tbl%0d_msg_ready", i), _rf_msg_ready, tbl[i].e_mrdy);
            check($sformatf("tbl%0d_msg_id", i), _rf_msg_rob_id, tbl[i].e_mid);
            check($sformatf("tbl%0d_msg_value", i), _rf_msg_value, tbl[i].e_mval);
            check_model();
            @(posedge clk_in);
            model_edge();
        end

        // Asynchronous reset in the middle of a cycle.
        run_cycle(mk(1, 0, 0, 0, 0, 1, 10, 5, 32'h1234, 5, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(mk(1, 0, 1, 3, 5, 1, 11, 9, 32'h42, 5, 0, 0, 0, 0, 0, 0, 0));
        #2;
        check("pre_reset_r5_dep", _read_has_dependency[0], 1'b1);
        check("pre_reset_msg_ready", _rf_msg_ready, 1'b1);
        rst_in = 1'b1;
        #1;
        check("reset_r5_dep", _read_has_dependency[0], 1'b0);
        check("reset_r5_val", _read_value[XLEN-1:0], 32'h0);
        check("reset_msg_ready", _rf_msg_ready, 1'b0);
        check("reset_msg_id", _rf_msg_rob_id, 5'h0);
        check("reset_msg_value", _rf_msg_value, 32'h0);
        @(negedge clk_in);
        drive(idle);
        rst_in = 1'b0;
        model_reset();

        // Randomized traffic against the model, biased toward low registers.
        for (int n = 0; n < 600; n++) begin
            int r;
            v = idle;
            v.rdy   = ($urandom_range(0, 9) != 0);
            v.flush = ($urandom_range(0, 19) == 0);
            v.lr    = $urandom_range(0, 1);
            v.lrob  = 5'($urandom);
            v.lreg  = 5'($urandom_range(0, 7));
            v.cr    = $urandom_range(0, 1);
            r       = $urandom_range(0, 7);
            v.crob  = (m_busy[r] && $urandom_range(0, 2) != 0) ? m_tag[r] : 5'($urandom);
            v.creg  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(r);
            v.cval  = $urandom;
            v.rd0   = 5'($urandom_range(0, 8));
            v.rd1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
            run_cycle(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
